// File: rtl/agc_pkg.sv
// Shared types and arithmetic helpers for the AGC re-pack path.
package agc_pkg;

    localparam int AGC_W         = 8;
    localparam int AGCS_PER_LANE = 8;
    localparam int AGCS_PER_SIDE = AGCS_PER_LANE / 2;
    localparam int LANE_AGC_W    = AGC_W * AGCS_PER_LANE;

    typedef logic [AGCS_PER_LANE-1:0][AGC_W-1:0] agc_lane_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        STREAM
    } agc_pack_st_t;

    // Signed base byte plus unsigned shift byte, widened to 10 bits.
    function automatic logic [9:0] agc_sum10(input logic [7:0] base, input logic [7:0] shift);
        return {{2{base[7]}}, base} + {2'b00, shift};
    endfunction

    // True when a 10-bit sum does not fit in a signed byte.
    function automatic logic agc_ovf(input logic signed [9:0] sum);
        return (sum[9:7] != 3'b000) && (sum[9:7] != 3'b111);
    endfunction

    // Clamp a 10-bit signed sum to [-128, 127].
    function automatic logic [7:0] sat8(input logic signed [9:0] sum);
        if (!agc_ovf(sum)) begin
            return sum[7:0];
        end else if (sum[9]) begin
            return 8'h80;
        end else begin
            return 8'h7F;
        end
    endfunction

endpackage

// File: rtl/agc_recon_lane.sv
// One lane of exponent reconstruction: eight saturating byte adders, registered.
module agc_recon_lane
    import agc_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [15:0]           i_base,
    input  logic [LANE_AGC_W-1:0] i_shift,
    output logic [LANE_AGC_W-1:0] o_agc,
    output logic                  o_sat
);

    agc_lane_t w_shift;
    agc_lane_t w_agc;
    logic      w_sat;
    agc_lane_t r_agc;
    logic      r_sat;

    assign w_shift = i_shift;

    // Lower half of the lane pairs with the even-antenna base, upper half with the odd one.
    always_comb begin
        w_agc = '0;
        w_sat = 1'b0;
        for (int unsigned k = 0; k < AGCS_PER_LANE; k++) begin
            if (k < AGCS_PER_SIDE) begin
                w_agc[k] = sat8(agc_sum10(i_base[7:0], w_shift[k]));
                w_sat    = w_sat | agc_ovf(agc_sum10(i_base[7:0], w_shift[k]));
            end else begin
                w_agc[k] = sat8(agc_sum10(i_base[15:8], w_shift[k]));
                w_sat    = w_sat | agc_ovf(agc_sum10(i_base[15:8], w_shift[k]));
            end
        end
    end

    // Register the reconstructed exponents and the saturation indication.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_agc <= '0;
            r_sat <= 1'b0;
        end else begin
            r_agc <= w_agc;
            r_sat <= w_sat;
        end
    end

    assign o_agc = r_agc;
    assign o_sat = r_sat;

endmodule

// File: rtl/agc_pack.sv
// AGC pack: rebuilds per-antenna exponents from {base, shift} and attaches one
// exponent set per symbol to the CPRI beat stream with a fixed 2-cycle latency.
module agc_pack
    import agc_pkg::*;
#(
    parameter int LANES      = 8,
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 7,
    parameter int SYMB_BEATS = 32
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [15:0]                  i_agc_base,
    input  logic [LANES*LANE_AGC_W-1:0]  i_agc_shift,
    input  logic                         i_agc_load,
    input  logic [LANES*DATA_W-1:0]      i_tx_data,
    input  logic [LANES*ADDR_W-1:0]      i_tx_addr,
    input  logic [LANES-1:0]             i_tx_last,
    input  logic [LANES-1:0]             i_tx_vld,
    output logic [LANES*DATA_W-1:0]      o_cpri_data,
    output logic [LANES*ADDR_W-1:0]      o_cpri_addr,
    output logic [LANES-1:0]             o_cpri_last,
    output logic [LANES-1:0]             o_cpri_vld,
    output logic [LANES*LANE_AGC_W-1:0]  o_fft_agc,
    output logic [LANES-1:0]             o_symb_eop,
    output logic                         o_agc_sat,
    output logic                         o_agc_miss,
    output logic                         o_len_err
);

    localparam int CNT_W = (SYMB_BEATS > 1) ? $clog2(SYMB_BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMB_BEATS - 1);

    agc_pack_st_t r_state;
    agc_pack_st_t w_state_nxt;

    logic [15:0]                 r_shd_base;
    logic [LANES*LANE_AGC_W-1:0] r_shd_shift;
    logic                        r_shd_vld;
    logic                        w_shd_vld_nxt;
    logic [15:0]                 r_act_base;
    logic [LANES*LANE_AGC_W-1:0] r_act_shift;
    logic [CNT_W-1:0]            r_cnt;

    logic [LANES*DATA_W-1:0]     r_s1_data;
    logic [LANES*ADDR_W-1:0]     r_s1_addr;
    logic [LANES-1:0]            r_s1_last;
    logic                        r_s1_vld;
    logic                        r_s1_eop;

    logic                        w_vld;
    logic                        w_start;
    logic                        w_cnt_end;
    logic                        w_end;
    logic                        w_force;
    logic                        w_miss;
    logic [LANES-1:0]            w_lane_sat;
    logic                        w_unused_vld;

    // Only lane 0 qualifies beats; the other lanes' valid bits are ignored.
    assign w_unused_vld = ^i_tx_vld;

    assign w_vld     = i_tx_vld[0];
    assign w_start   = w_vld && (r_state != STREAM);
    assign w_cnt_end = (r_cnt == CNT_LAST);
    assign w_end     = w_vld && (i_tx_last[0] || w_cnt_end);
    assign w_force   = w_vld && w_cnt_end && !i_tx_last[0];
    assign w_miss    = w_start && !i_agc_load && !r_shd_vld;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: after an end beat, ARMED/IDLE follows whether a fresh load is pending.
    always_comb begin
        w_state_nxt   = r_state;
        w_shd_vld_nxt = r_shd_vld;
        if (w_start) begin
            w_shd_vld_nxt = 1'b0;
        end else if (i_agc_load) begin
            w_shd_vld_nxt = 1'b1;
        end
        case (r_state)
            IDLE, ARMED: begin
                if (w_vld) begin
                    if (w_end) begin
                        w_state_nxt = w_shd_vld_nxt ? ARMED : IDLE;
                    end else begin
                        w_state_nxt = STREAM;
                    end
                end else if (i_agc_load) begin
                    w_state_nxt = ARMED;
                end
            end
            STREAM: begin
                if (w_end) begin
                    w_state_nxt = w_shd_vld_nxt ? ARMED : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shadow register: last load wins until a symbol start consumes it.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_shd_base  <= '0;
            r_shd_shift <= '0;
            r_shd_vld   <= 1'b0;
        end else begin
            if (i_agc_load) begin
                r_shd_base  <= i_agc_base;
                r_shd_shift <= i_agc_shift;
            end
            r_shd_vld <= w_shd_vld_nxt;
        end
    end

    // Active register: updated only at symbol start; a coincident load bypasses the shadow.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_act_base  <= '0;
            r_act_shift <= '0;
        end else if (w_start) begin
            if (i_agc_load) begin
                r_act_base  <= i_agc_base;
                r_act_shift <= i_agc_shift;
            end else if (r_shd_vld) begin
                r_act_base  <= r_shd_base;
                r_act_shift <= r_shd_shift;
            end
        end
    end

    // Beat counter: valid beats seen so far in the current symbol.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (w_vld) begin
            r_cnt <= w_end ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // First delay stage; last/eop are qualified by lane-0 valid here.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_s1_data <= '0;
            r_s1_addr <= '0;
            r_s1_last <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_eop  <= 1'b0;
        end else begin
            r_s1_data <= i_tx_data;
            r_s1_addr <= i_tx_addr;
            r_s1_vld  <= w_vld;
            r_s1_eop  <= w_end;
            if (!w_vld) begin
                r_s1_last <= '0;
            end else if (w_force) begin
                r_s1_last <= '1;
            end else begin
                r_s1_last <= i_tx_last;
            end
        end
    end

    // Second delay stage drives the CPRI outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_cpri_data <= '0;
            o_cpri_addr <= '0;
            o_cpri_last <= '0;
            o_cpri_vld  <= '0;
            o_symb_eop  <= '0;
        end else begin
            o_cpri_data <= r_s1_data;
            o_cpri_addr <= r_s1_addr;
            o_cpri_last <= r_s1_last;
            o_cpri_vld  <= {LANES{r_s1_vld}};
            o_symb_eop  <= {LANES{r_s1_eop}};
        end
    end

    // Reconstruction reads the active register, so its registered output lines up
    // with the second delay stage of the symbol's first beat.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        agc_recon_lane u_lane (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_base  (r_act_base),
            .i_shift (r_act_shift[g*LANE_AGC_W +: LANE_AGC_W]),
            .o_agc   (o_fft_agc[g*LANE_AGC_W +: LANE_AGC_W]),
            .o_sat   (w_lane_sat[g])
        );
    end

    // Sticky status flags.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_agc_sat  <= 1'b0;
            o_agc_miss <= 1'b0;
            o_len_err  <= 1'b0;
        end else begin
            if (|w_lane_sat) begin
                o_agc_sat <= 1'b1;
            end
            if (w_miss) begin
                o_agc_miss <= 1'b1;
            end
            if (w_force) begin
                o_len_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_agc_pack.sv
// Bench for agc_pack: randomized beats and loads against a behavioural model,
// plus directed scenarios with hand-computed exponent values.
module tb_agc_pack;

    localparam int LANES      = 8;
    localparam int DATA_W     = 64;
    localparam int ADDR_W     = 7;
    localparam int SYMB_BEATS = 32;
    localparam int AW         = LANES * 64;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [15:0]               i_agc_base;
    logic [AW-1:0]             i_agc_shift;
    logic                      i_agc_load;
    logic [LANES*DATA_W-1:0]   i_tx_data;
    logic [LANES*ADDR_W-1:0]   i_tx_addr;
    logic [LANES-1:0]          i_tx_last;
    logic [LANES-1:0]          i_tx_vld;
    logic [LANES*DATA_W-1:0]   o_cpri_data;
    logic [LANES*ADDR_W-1:0]   o_cpri_addr;
    logic [LANES-1:0]          o_cpri_last;
    logic [LANES-1:0]          o_cpri_vld;
    logic [AW-1:0]             o_fft_agc;
    logic [LANES-1:0]          o_symb_eop;
    logic                      o_agc_sat;
    logic                      o_agc_miss;
    logic                      o_len_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    logic [15:0]             m_shd_b, m_act_b;
    logic [AW-1:0]           m_shd_s, m_act_s;
    bit                      m_fresh, m_open, m_sat, m_miss, m_len;
    int                      m_cnt;
    logic [LANES*DATA_W-1:0] e_data [2];
    logic [LANES*ADDR_W-1:0] e_addr [2];
    logic [LANES-1:0]        e_last [2];
    logic [LANES-1:0]        e_vld  [2];
    logic [LANES-1:0]        e_eop  [2];
    logic [AW-1:0]           e_agc  [2];

    always #5 clk = ~clk;

    agc_pack #(
        .LANES      (LANES),
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .SYMB_BEATS (SYMB_BEATS)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_agc_base  (i_agc_base),
        .i_agc_shift (i_agc_shift),
        .i_agc_load  (i_agc_load),
        .i_tx_data   (i_tx_data),
        .i_tx_addr   (i_tx_addr),
        .i_tx_last   (i_tx_last),
        .i_tx_vld    (i_tx_vld),
        .o_cpri_data (o_cpri_data),
        .o_cpri_addr (o_cpri_addr),
        .o_cpri_last (o_cpri_last),
        .o_cpri_vld  (o_cpri_vld),
        .o_fft_agc   (o_fft_agc),
        .o_symb_eop  (o_symb_eop),
        .o_agc_sat   (o_agc_sat),
        .o_agc_miss  (o_agc_miss),
        .o_len_err   (o_len_err)
    );

    function automatic logic [AW-1:0] recon_all(input logic [15:0] b, input logic [AW-1:0] s);
        logic [AW-1:0]      r;
        logic signed [7:0]  bb;
        int                 v;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < 8; k++) begin
                bb = (k < 4) ? b[7:0] : b[15:8];
                v  = int'(bb) + int'(s[l*64 + k*8 +: 8]);
                if (v > 127)  v = 127;
                if (v < -128) v = -128;
                r[l*64 + k*8 +: 8] = v[7:0];
            end
        end
        return r;
    endfunction

    function automatic bit any_sat(input logic [15:0] b, input logic [AW-1:0] s);
        logic signed [7:0] bb;
        int                v;
        bit                f;
        f = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < 8; k++) begin
                bb = (k < 4) ? b[7:0] : b[15:8];
                v  = int'(bb) + int'(s[l*64 + k*8 +: 8]);
                if (v > 127 || v < -128) f = 1'b1;
            end
        end
        return f;
    endfunction

    // Model: each input beat produces one expected output record, emerging two edges later.
    always @(posedge clk) begin
        bit vld0, l0, at_limit;
        if (!rst_n) begin
            m_shd_b = '0; m_shd_s = '0; m_act_b = '0; m_act_s = '0;
            m_fresh = 0; m_open = 0; m_sat = 0; m_miss = 0; m_len = 0; m_cnt = 0;
            for (int i = 0; i < 2; i++) begin
                e_data[i] = '0; e_addr[i] = '0; e_last[i] = '0;
                e_vld[i] = '0; e_eop[i] = '0; e_agc[i] = '0;
            end
        end else begin
            e_data[1] = e_data[0]; e_addr[1] = e_addr[0]; e_last[1] = e_last[0];
            e_vld[1]  = e_vld[0];  e_eop[1]  = e_eop[0];  e_agc[1]  = e_agc[0];
            vld0 = i_tx_vld[0];
            l0   = i_tx_last[0];
            e_data[0] = i_tx_data;
            e_addr[0] = i_tx_addr;
            e_vld[0]  = {LANES{vld0}};
            if (vld0) begin
                if (!m_open) begin
                    if (i_agc_load) begin
                        m_act_b = i_agc_base; m_act_s = i_agc_shift;
                    end else if (m_fresh) begin
                        m_act_b = m_shd_b; m_act_s = m_shd_s;
                    end else begin
                        m_miss = 1'b1;
                    end
                    m_fresh = 1'b0;
                    if (any_sat(m_act_b, m_act_s)) m_sat = 1'b1;
                end else if (i_agc_load) begin
                    m_shd_b = i_agc_base; m_shd_s = i_agc_shift; m_fresh = 1'b1;
                end
                at_limit  = (m_cnt == SYMB_BEATS - 1);
                e_last[0] = (at_limit && !l0) ? '1 : i_tx_last;
                e_eop[0]  = (at_limit || l0) ? '1 : '0;
                if (at_limit && !l0) m_len = 1'b1;
                if (at_limit || l0) begin
                    m_open = 1'b0; m_cnt = 0;
                end else begin
                    m_open = 1'b1; m_cnt++;
                end
            end else begin
                if (i_agc_load) begin
                    m_shd_b = i_agc_base; m_shd_s = i_agc_shift; m_fresh = 1'b1;
                end
                e_last[0] = '0;
                e_eop[0]  = '0;
            end
            e_agc[0] = recon_all(m_act_b, m_act_s);
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (o_cpri_data !== e_data[1]) begin
                errors++;
                $display("FAIL data t=%0t got %h expected %h", $time, o_cpri_data, e_data[1]);
            end
            checks++;
            if (o_cpri_addr !== e_addr[1]) begin
                errors++;
                $display("FAIL addr t=%0t got %h expected %h", $time, o_cpri_addr, e_addr[1]);
            end
            checks++;
            if ({o_cpri_vld, o_cpri_last, o_symb_eop} !== {e_vld[1], e_last[1], e_eop[1]}) begin
                errors++;
                $display("FAIL ctrl t=%0t got vld/last/eop %h/%h/%h expected %h/%h/%h", $time,
                         o_cpri_vld, o_cpri_last, o_symb_eop, e_vld[1], e_last[1], e_eop[1]);
            end
            if (e_vld[1][0]) begin
                checks++;
                if (o_fft_agc !== e_agc[1]) begin
                    errors++;
                    $display("FAIL agc t=%0t got %h expected %h", $time, o_fft_agc, e_agc[1]);
                end
            end
        end
    end

    task automatic expect_v(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_flags(input string name);
        expect_v({name, "_sat"},  {63'd0, o_agc_sat},  {63'd0, m_sat});
        expect_v({name, "_miss"}, {63'd0, o_agc_miss}, {63'd0, m_miss});
        expect_v({name, "_len"},  {63'd0, o_len_err},  {63'd0, m_len});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit v, input bit l0);
        for (int i = 0; i < LANES*DATA_W/32; i++) i_tx_data[i*32 +: 32] = $urandom();
        for (int i = 0; i < LANES; i++) i_tx_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom());
        i_tx_last   = LANES'($urandom());
        i_tx_vld    = LANES'($urandom());
        i_tx_vld[0] = v;
        i_tx_last[0] = l0;
        cyc();
        i_agc_load = 1'b0;
    endtask

    task automatic arm_load(input logic [15:0] b, input logic [63:0] lane_s);
        i_agc_base = b;
        for (int l = 0; l < LANES; l++) i_agc_shift[l*64 +: 64] = lane_s;
        i_agc_load = 1'b1;
    endtask

    task automatic arm_load_rand();
        i_agc_base = 16'($urandom());
        for (int l = 0; l < LANES; l++) i_agc_shift[l*64 +: 64] = {$urandom(), $urandom()};
        i_agc_load = 1'b1;
    endtask

    task automatic symbol(input int n, input bit with_last);
        for (int i = 0; i < n; i++) beat(1'b1, with_last && (i == n - 1));
    endtask

    task automatic drain();
        repeat (3) beat(1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; i_agc_load = 1'b0; i_agc_base = '0; i_agc_shift = '0;
        i_tx_data = '0; i_tx_addr = '0; i_tx_last = '0; i_tx_vld = '0;
        repeat (3) cyc();
        chk_en = 1'b1;
        expect_v("rst_vld",  {56'd0, o_cpri_vld}, 64'h0);
        expect_v("rst_eop",  {56'd0, o_symb_eop}, 64'h0);
        expect_v("rst_agc",  o_fft_agc[63:0], 64'h0);
        expect_v("rst_flags", {61'd0, o_agc_sat, o_agc_miss, o_len_err}, 64'h0);
        rst_n = 1'b1;
        beat(1'b0, 1'b0);

        // Single 32-beat symbol, last on beat 31
        arm_load(16'hFD02, 64'h0706050403020100);
        beat(1'b0, 1'b0);
        symbol(32, 1'b1);
        beat(1'b0, 1'b0);
        expect_v("s1_eop",    {56'd0, o_symb_eop}, 64'hFF);
        expect_v("s1_agc_l0", o_fft_agc[63:0],   64'h04030201_05040302);
        expect_v("s1_agc_l7", o_fft_agc[511:448], 64'h04030201_05040302);
        beat(1'b0, 1'b0);
        expect_v("s1_eop_after", {56'd0, o_symb_eop}, 64'h0);
        expect_v("s1_flags", {61'd0, o_agc_sat, o_agc_miss, o_len_err}, 64'h0);

        // Saturation boundaries
        arm_load(16'h8080, 64'h0);
        beat(1'b0, 1'b0);
        symbol(4, 1'b1);
        beat(1'b0, 1'b0);
        expect_v("min_agc", o_fft_agc[63:0], 64'h80808080_80808080);
        beat(1'b0, 1'b0);
        expect_v("min_nosat", {63'd0, o_agc_sat}, 64'h0);
        arm_load(16'h007E, 64'h05050505_05050505);
        beat(1'b0, 1'b0);
        symbol(4, 1'b1);
        beat(1'b0, 1'b0);
        expect_v("sat_agc", o_fft_agc[63:0], 64'h05050505_7F7F7F7F);
        beat(1'b0, 1'b0);
        expect_v("sat_flag", {63'd0, o_agc_sat}, 64'h1);

        // Load during a symbol applies to the next one
        arm_load(16'h0101, 64'h0);
        beat(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) arm_load(16'h0909, 64'h0);
            beat(1'b1, i == 5);
        end
        beat(1'b0, 1'b0);
        expect_v("mid_load_cur", o_fft_agc[63:0], 64'h01010101_01010101);
        symbol(4, 1'b1);
        beat(1'b0, 1'b0);
        expect_v("mid_load_next", o_fft_agc[63:0], 64'h09090909_09090909);
        expect_v("mid_load_nomiss", {63'd0, o_agc_miss}, 64'h0);

        // Load coincident with the start beat
        beat(1'b0, 1'b0);
        arm_load(16'h0303, 64'h0);
        symbol(3, 1'b1);
        beat(1'b0, 1'b0);
        expect_v("coinc_agc", o_fft_agc[63:0], 64'h03030303_03030303);

        // Symbol with no fresh load repeats the previous exponents
        symbol(5, 1'b1);
        beat(1'b0, 1'b0);
        expect_v("miss_agc", o_fft_agc[63:0], 64'h03030303_03030303);
        beat(1'b0, 1'b0);
        expect_v("miss_flag", {63'd0, o_agc_miss}, 64'h1);

        // Missing last: forced end at beat 31, then a normal symbol
        symbol(32, 1'b0);
        beat(1'b0, 1'b0);
        expect_v("force_eop",  {56'd0, o_symb_eop},  64'hFF);
        expect_v("force_last", {56'd0, o_cpri_last}, 64'hFF);
        expect_v("force_len",  {63'd0, o_len_err},   64'h1);
        symbol(5, 1'b1);
        drain();
        check_flags("directed");

        // Randomized traffic and loads
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 11) == 0) arm_load_rand();
            beat($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        drain();
        check_flags("random");

        // Reset in the middle of a symbol
        arm_load(16'h0707, 64'h0);
        beat(1'b0, 1'b0);
        repeat (10) beat(1'b1, 1'b0);
        rst_n = 1'b0;
        beat(1'b1, 1'b0);
        expect_v("mrst_vld",  {56'd0, o_cpri_vld}, 64'h0);
        expect_v("mrst_eop",  {56'd0, o_symb_eop}, 64'h0);
        expect_v("mrst_data", o_cpri_data[63:0], 64'h0);
        expect_v("mrst_agc",  o_fft_agc[63:0], 64'h0);
        expect_v("mrst_flags", {61'd0, o_agc_sat, o_agc_miss, o_len_err}, 64'h0);
        rst_n = 1'b1;
        repeat (4) beat(1'b0, 1'b0);
        arm_load(16'h0A05, 64'h0);
        beat(1'b0, 1'b0);
        symbol(3, 1'b1);
        beat(1'b0, 1'b0);
        expect_v("post_rst_eop", {56'd0, o_symb_eop}, 64'hFF);
        expect_v("post_rst_agc", o_fft_agc[63:0], 64'h0A0A0A0A_05050505);
        drain();
        check_flags("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
